// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns held LC-3b mem_read/mem_write requests into single pmem transactions with byte-lane steering.
// Defining MEM_TIMEOUT_EN aborts a WAIT state after TIMEOUT_CYCLES and flags req_err.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_resp,
    output logic [15:0] req_rdata,
    output logic        mdr_load,
    output logic        req_err,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [15:0] pmem_rdata
);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;
    state_t state, state_n;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic [1:0] be_q;
    logic byte_q, rd_q, err_q, timeout;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic wait_st;
    assign wait_st = (state == READ_WAIT) || (state == WRITE_WAIT);
    always_ff @(posedge clk) begin
        if (reset || !wait_st) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
    assign timeout = wait_st && !pmem_resp && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = req_read ? READ_WAIT : req_write ? WRITE_WAIT : IDLE;
        else if (state == DONE) state_n = IDLE;
        else if (pmem_resp || timeout) state_n = DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            byte_q  <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && (req_read || req_write)) begin
                addr_q  <= req_addr;
                byte_q  <= req_byte;
                rd_q    <= req_read;
                wdata_q <= req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
                be_q    <= (req_read || !req_byte) ? 2'b11 : req_addr[0] ? 2'b10 : 2'b01;
                err_q   <= 1'b0;
            end
            if (state == READ_WAIT && pmem_resp)
                rdata_q <= byte_q ? {8'h00, addr_q[0] ? pmem_rdata[15:8] : pmem_rdata[7:0]} : pmem_rdata;
            if (timeout) err_q <= 1'b1;
        end
    end
    // err_q only stands when a timeout forced DONE, so it also suppresses the MDR load
    assign req_resp         = state == DONE;
    assign mdr_load         = req_resp && rd_q && !err_q;
    assign req_err          = req_resp && err_q;
    assign req_rdata        = rdata_q;
    assign pmem_read        = state == READ_WAIT;
    assign pmem_write       = state == WRITE_WAIT;
    assign pmem_address     = {addr_q[15:1], 1'b0};
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl timing, lane steering and reset abort.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_resp, mdr_load, req_err, pmem_read, pmem_write;
    logic [15:0] req_rdata, pmem_address, pmem_wdata, pmem_rdata = '0;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp = 1'b0;
    int checks = 0, errors = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata), .mdr_load(mdr_load), .req_err(req_err),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic byt, input logic [15:0] a, input logic [15:0] wd);
        req_read = rd; req_write = wr; req_byte = byt; req_addr = a; req_wdata = wd;
    endtask

    task automatic drop();
        req_read = 1'b0; req_write = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_resp", 16'(req_resp), 16'h0);
        chk("rst_rdata", req_rdata, 16'h0);
        chk("rst_strobes", 16'({mdr_load, req_err, pmem_read, pmem_write}), 16'h0);
        chk("rst_addr", pmem_address, 16'h0);
        chk("rst_wdata", pmem_wdata, 16'h0);
        chk("rst_be", 16'(pmem_byte_enable), 16'h0);
        reset = 1'b0;
        tick();
        // word read, resp two cycles late, request changes mid-transaction
        req(1, 0, 0, 16'h3001, 16'h0);
        tick();
        chk("wr_c1_read", 16'(pmem_read), 16'h1);
        chk("wr_c1_addr", pmem_address, 16'h3000);
        chk("wr_c1_be", 16'(pmem_byte_enable), 16'h3);
        req_addr = 16'h7777; req_byte = 1'b1;
        tick();
        chk("wr_c2_resp", 16'(req_resp), 16'h0);
        chk("wr_c2_addr_stable", pmem_address, 16'h3000);
        pmem_resp = 1'b1; pmem_rdata = 16'hBEEF;
        tick();
        pmem_resp = 1'b0; pmem_rdata = 16'h0;
        chk("wr_c4_resp", 16'(req_resp), 16'h1);
        chk("wr_c4_mdr_load", 16'(mdr_load), 16'h1);
        chk("wr_c4_rdata", req_rdata, 16'hBEEF);
        chk("wr_c4_read_low", 16'(pmem_read), 16'h0);
        drop();
        tick();
        chk("wr_c5_resp", 16'(req_resp), 16'h0);
        chk("wr_c5_rdata_hold", req_rdata, 16'hBEEF);
        // LDB odd and even
        req(1, 0, 1, 16'h4003, 16'h0);
        tick();
        chk("ldb_be", 16'(pmem_byte_enable), 16'h3);
        chk("ldb_addr", pmem_address, 16'h4002);
        pmem_resp = 1'b1; pmem_rdata = 16'hA55A;
        tick();
        pmem_resp = 1'b0; drop();
        chk("ldb_odd_rdata", req_rdata, 16'h00A5);
        chk("ldb_odd_resp", 16'(req_resp), 16'h1);
        tick();
        req(1, 0, 1, 16'h4002, 16'h0);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; drop();
        chk("ldb_even_rdata", req_rdata, 16'h005A);
        tick();
        // STB odd address
        req(0, 1, 1, 16'h5001, 16'h12C3);
        tick();
        chk("stb_write", 16'({pmem_write, pmem_read}), 16'h2);
        chk("stb_wdata", pmem_wdata, 16'hC3C3);
        chk("stb_be", 16'(pmem_byte_enable), 16'h2);
        chk("stb_addr", pmem_address, 16'h5000);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; drop();
        chk("stb_resp", 16'(req_resp), 16'h1);
        chk("stb_mdr_load", 16'(mdr_load), 16'h0);
        chk("stb_rdata_hold", req_rdata, 16'h005A);
        tick();
        // STB even, then word write
        req(0, 1, 1, 16'h5000, 16'hAB34);
        tick();
        chk("stb_even_be", 16'(pmem_byte_enable), 16'h1);
        chk("stb_even_wdata", pmem_wdata, 16'h3434);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; drop();
        tick();
        req(0, 1, 0, 16'h6001, 16'h1234);
        tick();
        chk("sw_be", 16'(pmem_byte_enable), 16'h3);
        chk("sw_wdata", pmem_wdata, 16'h1234);
        chk("sw_addr", pmem_address, 16'h6000);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; drop();
        tick();
        // read and write together: read wins, single transaction
        req(1, 1, 0, 16'h7000, 16'hFFFF);
        tick();
        chk("both_strobes", 16'({pmem_read, pmem_write}), 16'h2);
        pmem_resp = 1'b1; pmem_rdata = 16'h1357;
        tick();
        pmem_resp = 1'b0;
        chk("both_resp", 16'(req_resp), 16'h1);
        chk("both_write_low", 16'(pmem_write), 16'h0);
        chk("both_rdata", req_rdata, 16'h1357);
        drop();
        tick();
        chk("both_after", 16'({req_resp, pmem_read, pmem_write}), 16'h0);
        // pmem_resp while idle is ignored
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("idle_resp_ignored", 16'({req_resp, pmem_read, pmem_write}), 16'h0);
        // reset while in READ_WAIT
        req(1, 0, 0, 16'h8000, 16'h0);
        tick();
        chk("rst_mid_read_on", 16'(pmem_read), 16'h1);
        reset = 1'b1; drop();
        tick();
        chk("rst_mid_read_off", 16'(pmem_read), 16'h0);
        chk("rst_mid_resp", 16'(req_resp), 16'h0);
        reset = 1'b0; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
        chk("rst_mid_late_resp", 16'({req_resp, pmem_read, mdr_load}), 16'h0);
        // unanswered read
        pmem_rdata = 16'h0;
        req(1, 0, 0, 16'h9000, 16'h0);
        tick();
        drop();
`ifdef MEM_TIMEOUT_EN
        tick(); tick(); tick();
        chk("to_wait4_read", 16'({pmem_read, req_resp}), 16'h2);
        tick();
        chk("to_resp", 16'(req_resp), 16'h1);
        chk("to_err", 16'(req_err), 16'h1);
        chk("to_mdr_load", 16'(mdr_load), 16'h0);
        chk("to_rdata_hold", req_rdata, 16'h0000);
        tick();
        req(1, 0, 0, 16'h9002, 16'h0);
        tick();
        drop();
        tick(); tick(); tick();
        pmem_resp = 1'b1; pmem_rdata = 16'h2468;
        tick();
        pmem_resp = 1'b0;
        chk("to_tie_err", 16'(req_err), 16'h0);
        chk("to_tie_rdata", req_rdata, 16'h2468);
`else
        begin
            int resp_seen = 0;
            for (int i = 0; i < 120; i++) begin
                tick();
                if (req_resp) resp_seen++;
            end
            chk("no_to_read_held", 16'(pmem_read), 16'h1);
            chk("no_to_no_resp", 16'(resp_seen), 16'h0);
            chk("no_to_err", 16'(req_err), 16'h0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("no_to_cleared", 16'(pmem_read), 16'h0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
